// File: rtl/alu_cmd_issue.sv
// Command-issue stage: FIFO-buffered {A,B,op} to the ALU, registered result out.
// Optional perf counters (done_cnt, dz_cnt) under ALU_CMD_ISSUE_PERF_EN.
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [2:0]       in_op,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] fill
`ifdef ALU_CMD_ISSUE_PERF_EN
  ,
  output logic [15:0]      done_cnt,
  output logic [7:0]       dz_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [15:0]      a_mem  [DEPTH];
  logic [15:0]      b_mem  [DEPTH];
  logic [2:0]       op_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic             out_err_q;

  logic push, pop, empty, dz;

  assign empty    = (fill_q == '0);
  assign in_ready = (fill_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid_q || out_ready);

  assign alu_a  = empty ? 16'h0 : a_mem[rd_ptr_q];
  assign alu_b  = empty ? 16'h0 : b_mem[rd_ptr_q];
  assign alu_op = empty ? 3'h0  : op_mem[rd_ptr_q];

  // Divide by zero: substitute all-ones and flag, ignoring the ALU.
  assign dz = (alu_op == 3'b011) && (alu_b == 16'h0);

  always_comb begin
    fill_d = fill_q;
    if (push && !pop)
      fill_d = fill_q + 1'b1;
    else if (!push && pop)
      fill_d = fill_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q]  <= in_a;
      b_mem[wr_ptr_q]  <= in_b;
      op_mem[wr_ptr_q] <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      fill_q <= fill_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= dz ? 32'hFFFF_FFFF : alu_result;
        out_err_q   <= dz;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign fill      = fill_q;

`ifdef ALU_CMD_ISSUE_PERF_EN
  logic [15:0] done_cnt_q;
  logic [7:0]  dz_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
      dz_cnt_q   <= '0;
    end else begin
      if (out_valid_q && out_ready)
        done_cnt_q <= done_cnt_q + 1'b1;
      if (pop && dz && (dz_cnt_q != 8'hFF))
        dz_cnt_q <= dz_cnt_q + 1'b1;
    end
  end

  assign done_cnt = done_cnt_q;
  assign dz_cnt   = dz_cnt_q;
`endif

endmodule
